mem_ctrl: RTL and testbench

//  Responder end of the byte-wide memory request interface driven by the IF and MEM stages.

---
 rtl/mem_ctrl_pkg.sv | 13 +
 rtl/mem_ctrl_io_throttle.sv | 38 +++
 rtl/mem_ctrl.sv | 115 +++++++++++
 tb/tb_mem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared stall codes and bus-owner encodings for the memory request controller.
package mem_ctrl_pkg;

  localparam logic [1:0] STL_NONE = 2'b00;
  localparam logic [1:0] STALL    = 2'b01;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_IF   = 2'd1,
    MC_MEM  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_ctrl_io_throttle.sv
// Cooldown counter that blocks MEM writes to the IO (UART) address while the IO
// path is busy. Only instantiated when MEMCTRL_IO_THROTTLE_EN is defined.
module mem_ctrl_io_throttle #(
  parameter logic [31:0] IO_ADDR     = 32'h30000,
  parameter int          IO_COOLDOWN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        grant_mem,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic        io_full,
  output logic        blk
);

  localparam int CW = (IO_COOLDOWN < 2) ? 1 : $clog2(IO_COOLDOWN + 1);

  logic [CW-1:0] cooldown;
  logic          io_wr;

  assign io_wr = grant_mem & mem_we & (mem_addr == IO_ADDR);
  assign blk   = io_wr & (io_full | (cooldown != '0));

  // An accepted IO write restarts the cooldown; otherwise it drains one per rdy cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cooldown <= '0;
    end else if (rdy) begin
      if (io_wr && !blk) begin
        cooldown <= CW'(IO_COOLDOWN);
      end else if (cooldown != '0) begin
        cooldown <= cooldown - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-bus arbiter between IF and MEM requesters (MEM has priority, grant locked per
// transaction). Optional IO write throttling is enabled by MEMCTRL_IO_THROTTLE_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] IO_ADDR     = 32'h30000,
  parameter int          IO_COOLDOWN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_i,
  input  logic              if_re_i,
  input  logic [31:0]       if_addr_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [7:0]        mem_wdata_i,
  input  logic              io_full_i,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        rdata_o,
  output logic [1:0]        stl_if_o,
  output logic [1:0]        stl_mem_o
);

  owner_t owner;
  owner_t grant;
  logic   mem_req;
  logic   blk;

  assign mem_req = mem_re_i | mem_we_i;

  // The current owner keeps the bus while it still requests; otherwise MEM beats IF.
  always_comb begin
    grant = MC_IDLE;
    if (rst) begin
      grant = MC_IDLE;
    end else if (owner == MC_MEM && mem_req) begin
      grant = MC_MEM;
    end else if (owner == MC_IF && if_re_i) begin
      grant = MC_IF;
    end else if (mem_req) begin
      grant = MC_MEM;
    end else if (if_re_i) begin
      grant = MC_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= MC_IDLE;
    end else if (rdy_i) begin
      owner <= grant;
    end
  end

`ifdef MEMCTRL_IO_THROTTLE_EN
  mem_ctrl_io_throttle #(
    .IO_ADDR     (IO_ADDR),
    .IO_COOLDOWN (IO_COOLDOWN)
  ) u_io_throttle (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy_i),
    .grant_mem (grant == MC_MEM),
    .mem_we    (mem_we_i),
    .mem_addr  (mem_addr_i),
    .io_full   (io_full_i),
    .blk       (blk)
  );
`else
  logic unused_cfg;
  assign blk        = 1'b0;
  assign unused_cfg = ^{io_full_i, IO_ADDR, 32'(IO_COOLDOWN)};
`endif

  always_comb begin
    ram_a_o    = '0;
    ram_dout_o = 8'h00;
    ram_wr_o   = 1'b0;
    case (grant)
      MC_MEM: begin
        ram_a_o    = mem_addr_i[ADDR_W-1:0];
        ram_dout_o = mem_wdata_i;
        ram_wr_o   = mem_we_i & ~blk & rdy_i;
      end
      MC_IF: begin
        ram_a_o = if_addr_i[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  // A frozen bus (rdy_i low) stalls both stages regardless of ownership.
  always_comb begin
    stl_if_o  = STL_NONE;
    stl_mem_o = STL_NONE;
    if (rst) begin
      stl_if_o  = STL_NONE;
      stl_mem_o = STL_NONE;
    end else if (!rdy_i) begin
      stl_if_o  = STALL;
      stl_mem_o = STALL;
    end else begin
      if (if_re_i && grant != MC_IF) stl_if_o = STALL;
      if (mem_req && (grant != MC_MEM || blk)) stl_mem_o = STALL;
    end
  end

  assign rdata_o = rst ? 8'h00 : ram_din_i;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vectors with literal checks plus a
// per-cycle comparison against a transaction-level model of the arbiter.
module tb_mem_ctrl;

  localparam logic [31:0] IO_ADDR     = 32'h30000;
  localparam int          IO_COOLDOWN = 2;

  logic        clk = 1'b0;
  logic        rst, rdy, if_re, mem_re, mem_we, io_full;
  logic [31:0] if_addr, mem_addr, ram_a;
  logic [7:0]  mem_wdata, ram_dout, ram_din, rdata;
  logic        ram_wr;
  logic [1:0]  stl_if, stl_mem;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram [0:1023];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .IO_ADDR(IO_ADDR), .IO_COOLDOWN(IO_COOLDOWN)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy_i       (rdy),
    .if_re_i     (if_re),
    .if_addr_i   (if_addr),
    .mem_re_i    (mem_re),
    .mem_we_i    (mem_we),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .io_full_i   (io_full),
    .ram_a_o     (ram_a),
    .ram_dout_o  (ram_dout),
    .ram_wr_o    (ram_wr),
    .ram_din_i   (ram_din),
    .rdata_o     (rdata),
    .stl_if_o    (stl_if),
    .stl_mem_o   (stl_mem)
  );

  // Simple synchronous byte RAM on the external bus side.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    ram_din <= ram[ram_a[9:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: 0 = nobody, 1 = IF, 2 = MEM ----------------
  int m_owner = 0;
`ifdef MEMCTRL_IO_THROTTLE_EN
  int rdy_cnt = 0;
  int last_io = -100;
`endif

  function automatic int exp_grant();
    bit mreq;
    mreq = mem_re || mem_we;
    if (rst) return 0;
    if (m_owner == 2 && mreq) return 2;
    if (m_owner == 1 && if_re) return 1;
    if (mreq) return 2;
    if (if_re) return 1;
    return 0;
  endfunction

  function automatic bit exp_blk();
`ifdef MEMCTRL_IO_THROTTLE_EN
    return exp_grant() == 2 && mem_we && mem_addr == IO_ADDR &&
           (io_full || (rdy_cnt - last_io) <= IO_COOLDOWN);
`else
    return 1'b0;
`endif
  endfunction

  int          e_g;
  bit          e_b;
  logic [31:0] e_a;

  always @(negedge clk) begin
    e_g = exp_grant();
    e_b = exp_blk();
    e_a = (e_g == 2) ? mem_addr : (e_g == 1) ? if_addr : 32'h0;
    chk("m_ram_a", ram_a, e_a);
    chk("m_dout", 32'(ram_dout), (e_g == 2) ? 32'(mem_wdata) : 32'h0);
    chk("m_wr", 32'(ram_wr), 32'(rdy && e_g == 2 && mem_we && !e_b));
    chk("m_stl_if", 32'(stl_if),
        rst ? 32'h0 : !rdy ? 32'h1 : 32'(if_re && e_g != 1));
    chk("m_stl_mem", 32'(stl_mem),
        rst ? 32'h0 : !rdy ? 32'h1 : 32'((mem_re || mem_we) && (e_g != 2 || e_b)));
    chk("m_rdata", 32'(rdata), rst ? 32'h0 : 32'(ram_din));
  end

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= 0;
`ifdef MEMCTRL_IO_THROTTLE_EN
      last_io <= -100;
`endif
    end else if (rdy) begin
      m_owner <= exp_grant();
`ifdef MEMCTRL_IO_THROTTLE_EN
      if (exp_grant() == 2 && mem_we && mem_addr == IO_ADDR && !exp_blk())
        last_io <= rdy_cnt;
      rdy_cnt <= rdy_cnt + 1;
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_inputs();
    rdy = 1'b1; if_re = 1'b0; mem_re = 1'b0; mem_we = 1'b0; io_full = 1'b0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 8'h00;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [31:0] word;
  bit          exp_wr_seq [0:7];
  bit          full_seq   [0:7];

  initial begin
    idle_inputs();
    rst = 1'b1;
    if_re = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 8'h77;
    mid();
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_wr", 32'(ram_wr), 32'h0);
    chk("rst_stl_if", 32'(stl_if), 32'h0);
    chk("rst_stl_mem", 32'(stl_mem), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    nxt(); nxt();
    rst = 1'b0; idle_inputs();
    nxt();

    // Seed 0x100 with 0xAB, then IF reads it back.
    mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 8'hAB;
    mid(); chk("seed_wr", 32'(ram_wr), 32'h1);
    nxt(); idle_inputs(); nxt();
    if_re = 1'b1; if_addr = 32'h100;
    mid();
    chk("if_ram_a", ram_a, 32'h100);
    chk("if_stl", 32'(stl_if), 32'h0);
    nxt(); if_re = 1'b0;
    mid(); chk("if_rdata", 32'(rdata), 32'hAB);
    $display("txn if_read addr=100 rdata=%0h", rdata);
    nxt();

    // MEM store word 0xDDCCBBAA as four bytes.
    word = 32'hDDCCBBAA;
    for (int i = 0; i < 4; i++) begin
      mem_we = 1'b1; mem_addr = 32'h200 + 32'(i); mem_wdata = word[8*i +: 8];
      mid();
      chk("sw_wr", 32'(ram_wr), 32'h1);
      chk("sw_dout", 32'(ram_dout), 32'(word[8*i +: 8]));
      chk("sw_stl_mem", 32'(stl_mem), 32'h0);
      $display("txn sw byte addr=%0h dout=%0h wr=%0b", ram_a, ram_dout, ram_wr);
      nxt();
    end
    idle_inputs();
    // Pipelined IF readback of the stored bytes.
    for (int i = 0; i < 5; i++) begin
      if_re = (i < 4); if_addr = (i < 4) ? 32'h200 + 32'(i) : 32'h0;
      mid();
      if (i > 0) begin
        chk("sw_readback", 32'(rdata), 32'(word[8*(i-1) +: 8]));
        $display("txn readback byte%0d rdata=%0h", i - 1, rdata);
      end
      nxt();
    end
    idle_inputs(); nxt();

    // Simultaneous IF and MEM requests from idle: MEM wins.
    if_re = 1'b1; if_addr = 32'h104; mem_re = 1'b1; mem_addr = 32'h201;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("sim_stl_if", 32'(stl_if), 32'h1);
      chk("sim_stl_mem", 32'(stl_mem), 32'h0);
      chk("sim_ram_a", ram_a, 32'h201);
      if (i == 1) chk("sim_rdata", 32'(rdata), 32'hBB);
      nxt();
    end
    mem_re = 1'b0;
    mid();
    chk("sim_release_stl_if", 32'(stl_if), 32'h0);
    chk("sim_release_ram_a", ram_a, 32'h104);
    $display("txn simultaneous release ram_a=%0h stl_if=%0b", ram_a, stl_if);
    nxt(); idle_inputs(); nxt();

    // IF owns the bus; MEM write must wait for IF to drop.
    if_re = 1'b1; if_addr = 32'h300;
    nxt();
    mem_we = 1'b1; mem_addr = 32'h204; mem_wdata = 8'h55;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("ifown_stl_mem", 32'(stl_mem), 32'h1);
      chk("ifown_wr", 32'(ram_wr), 32'h0);
      chk("ifown_stl_if", 32'(stl_if), 32'h0);
      nxt();
    end
    if_re = 1'b0;
    mid();
    chk("ifrel_wr", 32'(ram_wr), 32'h1);
    chk("ifrel_dout", 32'(ram_dout), 32'h55);
    chk("ifrel_stl_mem", 32'(stl_mem), 32'h0);
    $display("txn mem write after if release wr=%0b dout=%0h", ram_wr, ram_dout);
    nxt(); idle_inputs(); nxt();

    // rdy_i low for three cycles mid-MEM transaction.
    mem_re = 1'b1; mem_addr = 32'h200;
    nxt();
    rdy = 1'b0; mem_re = 1'b0; mem_we = 1'b1; mem_addr = 32'h205; mem_wdata = 8'h66;
    if_re = 1'b1; if_addr = 32'h104;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_we = 1'b0;
      mid();
      chk("frz_wr", 32'(ram_wr), 32'h0);
      chk("frz_stl_if", 32'(stl_if), 32'h1);
      chk("frz_stl_mem", 32'(stl_mem), 32'h1);
      nxt();
    end
    rdy = 1'b1; mem_re = 1'b1; mem_addr = 32'h201;
    mid();
    chk("resume_ram_a", ram_a, 32'h201);
    chk("resume_stl_if", 32'(stl_if), 32'h1);
    chk("resume_stl_mem", 32'(stl_mem), 32'h0);
    nxt(); idle_inputs();
    mid(); chk("resume_rdata", 32'(rdata), 32'hBB);
    $display("txn resume after freeze rdata=%0h", rdata);
    nxt();

    // Asynchronous reset mid-write drops the strobe immediately.
    mem_we = 1'b1; mem_addr = 32'h206; mem_wdata = 8'h77;
    mid(); chk("pre_rst_wr", 32'(ram_wr), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_wr", 32'(ram_wr), 32'h0);
    chk("async_rst_ram_a", ram_a, 32'h0);
    $display("txn async reset wr=%0b", ram_wr);
    nxt(); rst = 1'b0; idle_inputs(); nxt();

    // Back-to-back byte writes to the IO address.
    full_seq = '{0, 0, 0, 0, 1, 1, 1, 0};
`ifdef MEMCTRL_IO_THROTTLE_EN
    exp_wr_seq = '{1, 0, 0, 1, 0, 0, 0, 1};
`else
    exp_wr_seq = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
    for (int i = 0; i < 8; i++) begin
      mem_we = 1'b1; mem_addr = IO_ADDR; mem_wdata = 8'h41 + 8'(i); io_full = full_seq[i];
      mid();
      chk("io_wr", 32'(ram_wr), 32'(exp_wr_seq[i]));
      chk("io_stl_mem", 32'(stl_mem), 32'(!exp_wr_seq[i]));
      $display("txn io write %0d full=%0b wr=%0b stl_mem=%0b", i, io_full, ram_wr, stl_mem);
      nxt();
    end
    idle_inputs(); nxt();

    // Random traffic checked by the model only.
    for (int i = 0; i < 400; i++) begin
      int op;
      rdy = ($urandom_range(7) != 0);
      if_re = 1'($urandom);
      if_addr = 32'h200 + 32'($urandom_range(3));
      op = $urandom_range(2);
      mem_re = (op == 1);
      mem_we = (op == 2);
      mem_addr = ($urandom_range(3) == 0) ? IO_ADDR : 32'h200 + 32'($urandom_range(5));
      mem_wdata = 8'($urandom);
      io_full = ($urandom_range(3) == 0);
      nxt();
    end
    idle_inputs(); nxt(); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
